// File: rtl/sockit_ghrd_led_pio_out_if.sv
// Avalon-MM slave bus bundle for the LED output PIO: word address, select,
// active-low write strobe, write data and registered read data.
interface sockit_ghrd_led_pio_out_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/sockit_ghrd_led_pio_out.sv
// LED output PIO: CPU-writable data register with atomic set/clear, per-bit
// blink enable driven by a programmable half-period prescaler.
//
// Bus handshake: a write happens in every cycle where chipselect=1 and
// write_n=0 and takes effect at that clock edge; there is no wait state.
// readdata is registered from the address every cycle (chipselect not needed)
// and shows register contents as they were before that cycle's write.
module sockit_ghrd_led_pio_out #(
  parameter int                       WIDTH        = 4,
  parameter logic [WIDTH-1:0]         RESET_VALUE  = '0,
  parameter int                       PERIOD_WIDTH = 24,
  parameter logic [PERIOD_WIDTH-1:0]  RESET_PERIOD = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  sockit_ghrd_led_pio_out_if.slave bus,
  output logic [WIDTH-1:0]     out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1);

  logic [WIDTH-1:0]        data;
  logic [WIDTH-1:0]        blink_en;
  logic [PERIOD_WIDTH-1:0] period;
  logic [PERIOD_WIDTH-1:0] cnt;
  logic                    phase;

  logic                    wr;
  logic                    wr_data;
  logic                    wr_blink_en;
  logic                    wr_period;
  logic                    wr_outset;
  logic                    wr_outclear;
  logic [WIDTH-1:0]        wd_bits;
  logic [PERIOD_WIDTH-1:0] wd_period;
  logic [WIDTH-1:0]        data_next;
  logic [WIDTH-1:0]        led_next;
  logic [31:0]             rd_mux;

  // Bits above WIDTH / PERIOD_WIDTH are ignored by design.
  logic unused_wd;
  assign unused_wd = ^bus.writedata;

  assign wr          = bus.chipselect & ~bus.write_n;
  assign wr_data     = wr && (bus.address == ADDR_DATA);
  assign wr_blink_en = wr && (bus.address == ADDR_BLINK_EN);
  assign wr_period   = wr && (bus.address == ADDR_PERIOD);
  assign wr_outset   = wr && (bus.address == ADDR_OUTSET);
  assign wr_outclear = wr && (bus.address == ADDR_OUTCLEAR);
  assign wd_bits     = bus.writedata[WIDTH-1:0];
  assign wd_period   = bus.writedata[PERIOD_WIDTH-1:0];

  always_comb begin
    data_next = data;
    if (wr_data) begin
      data_next = wd_bits;
    end else if (wr_outset) begin
      data_next = data | wd_bits;
    end else if (wr_outclear) begin
      data_next = data & ~wd_bits;
    end
  end

  // Blinking bits follow data gated by phase; steady bits follow data.
  assign led_next = (data & ~blink_en) | (data & blink_en & {WIDTH{phase}});

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA:     rd_mux[WIDTH-1:0]        = data;
      ADDR_BLINK_EN: rd_mux[WIDTH-1:0]        = blink_en;
      ADDR_PERIOD:   rd_mux[PERIOD_WIDTH-1:0] = period;
      ADDR_STATUS:   rd_mux[0]                = phase;
      default:       rd_mux                   = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data     <= RESET_VALUE;
      blink_en <= '0;
    end else begin
      data <= data_next;
      if (wr_blink_en) begin
        blink_en <= wd_bits;
      end
    end
  end

  // A period write restarts the blink on phase; period 0 parks phase high.
  always_ff @(posedge clk) begin
    if (reset) begin
      period <= RESET_PERIOD;
      cnt    <= RESET_PERIOD;
      phase  <= 1'b1;
    end else if (wr_period) begin
      period <= wd_period;
      cnt    <= wd_period;
      phase  <= 1'b1;
    end else if (period == '0) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == '0) begin
      cnt   <= period;
      phase <= ~phase;
    end else begin
      cnt <= cnt - PERIOD_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.readdata <= '0;
      out_port     <= RESET_VALUE;
    end else begin
      bus.readdata <= rd_mux;
      out_port     <= led_next;
    end
  end

endmodule

// File: tb/tb_sockit_ghrd_led_pio_out.sv
// Random and directed stimulus for the LED PIO, checked against an elapsed-time
// model of the register file and blink phase through an expected-value queue.
module tb_sockit_ghrd_led_pio_out;
  localparam int         W  = 4;
  localparam int         PW = 24;
  localparam logic [W-1:0]  RV = 4'h6;
  localparam logic [PW-1:0] RP = 24'd2;

  logic         clk;
  logic         reset;
  logic [W-1:0] out_port;

  sockit_ghrd_led_pio_out_if bus_if ();

  sockit_ghrd_led_pio_out #(
    .WIDTH        (W),
    .RESET_VALUE  (RV),
    .PERIOD_WIDTH (PW),
    .RESET_PERIOD (RP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if.slave),
    .out_port (out_port)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {expected out_port, expected readdata}
  logic [W+31:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  logic [W-1:0]  m_data;
  logic [W-1:0]  m_blink;
  logic [PW-1:0] m_period;
  longint        m_t;

  // Phase starts high on a period load and flips every period+1 cycles after.
  function automatic logic m_phase();
    if (m_period == '0) return 1'b1;
    return ((m_t / (longint'(m_period) + 1)) % 2) == 0;
  endfunction

  function automatic logic [W-1:0] m_led();
    logic [W-1:0] v;
    logic         ph;
    ph = m_phase();
    for (int i = 0; i < W; i++) begin
      v[i] = m_blink[i] ? (m_data[i] & ph) : m_data[i];
    end
    return v;
  endfunction

  task automatic m_reset();
    m_data   = RV;
    m_blink  = '0;
    m_period = RP;
    m_t      = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // driver: one bus cycle
  task automatic drive(input logic [2:0] a, input logic cs, input logic wn,
                       input logic [31:0] wd, input logic rst);
    logic [31:0]  e_rd;
    logic [W-1:0] e_out;
    logic         wr;
    bus_if.address    = a;
    bus_if.chipselect = cs;
    bus_if.write_n    = wn;
    bus_if.writedata  = wd;
    reset             = rst;
    if (rst) begin
      e_rd  = '0;
      e_out = RV;
    end else begin
      case (a)
        3'd0:    e_rd = 32'(m_data);
        3'd1:    e_rd = 32'(m_blink);
        3'd2:    e_rd = 32'(m_period);
        3'd3:    e_rd = 32'(m_phase());
        default: e_rd = '0;
      endcase
      e_out = m_led();
    end
    @(posedge clk);
    exp_q.push_back({e_out, e_rd});
    cyc++;
    if (rst) begin
      m_reset();
    end else begin
      wr = cs & ~wn;
      if (wr && a == 3'd2) begin
        m_period = wd[PW-1:0];
        m_t      = 0;
      end else begin
        m_t++;
      end
      if (wr) begin
        case (a)
          3'd0: m_data  = wd[W-1:0];
          3'd1: m_blink = wd[W-1:0];
          3'd4: m_data  = m_data | wd[W-1:0];
          3'd5: m_data  = m_data & ~wd[W-1:0];
          default: ;
        endcase
      end
    end
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
    drive(a, 1'b1, 1'b0, wd, 1'b0);
  endtask

  task automatic idle(input logic [2:0] a, input int n);
    for (int i = 0; i < n; i++) drive(a, 1'b0, 1'b1, $urandom(), 1'b0);
  endtask

  // monitor: outputs are presented every cycle after an edge
  initial begin
    logic [W+31:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("readdata", bus_if.readdata, e[31:0]);
        check("out_port", 32'(out_port), 32'(e[W+31:32]));
      end
    end
  end

  initial begin
    logic [2:0]  a;
    logic [31:0] wd;
    m_reset();
    // reset state read-back of every readable register
    drive(3'd0, 1'b0, 1'b1, 32'h0, 1'b1);
    drive(3'd0, 1'b0, 1'b1, 32'h0, 1'b1);
    drive(3'd1, 1'b0, 1'b1, 32'h0, 1'b0);
    drive(3'd2, 1'b0, 1'b1, 32'h0, 1'b0);
    drive(3'd3, 1'b0, 1'b1, 32'h0, 1'b0);
    idle(3'd3, 6);
    // data, set, clear with high garbage bits
    wr_reg(3'd0, 32'hFFFF_FFF5);
    wr_reg(3'd4, 32'h0000_0002);
    wr_reg(3'd5, 32'hA5A5_A5A4);
    idle(3'd0, 3);
    // blink bit 0 with period 3, watched through STATUS
    wr_reg(3'd0, 32'h0000_000F);
    wr_reg(3'd1, 32'h0000_0001);
    wr_reg(3'd2, 32'hFF00_0003);
    idle(3'd3, 5);
    // stop blink while phase is low
    wr_reg(3'd2, 32'h0000_0000);
    idle(3'd3, 10);
    // write and read the same register in one cycle
    wr_reg(3'd0, 32'h0000_000A);
    idle(3'd0, 2);
    // unmapped addresses and read-only STATUS
    wr_reg(3'd3, 32'hFFFF_FFFF);
    wr_reg(3'd6, 32'hFFFF_FFFF);
    wr_reg(3'd7, 32'hFFFF_FFFF);
    idle(3'd6, 1);
    idle(3'd4, 1);
    // reset during an active blink
    wr_reg(3'd0, 32'h0000_000F);
    wr_reg(3'd1, 32'h0000_000F);
    wr_reg(3'd2, 32'h0000_0001);
    idle(3'd3, 5);
    drive(3'd2, 1'b0, 1'b1, 32'h0, 1'b1);
    idle(3'd2, 1);
    idle(3'd1, 1);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      a  = 3'($urandom_range(0, 7));
      wd = $urandom();
      if (a == 3'd2) wd = (wd & 32'hFF00_0000) | 32'($urandom_range(0, 6));
      drive(a, ($urandom_range(0, 9) < 8), ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1,
            wd, ($urandom_range(0, 149) == 0));
    end
    idle(3'd0, 2);
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
